// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port, synchronous-read framebuffer RAM
// (160x120, 8-bit pixels) between VGA scanout and a buffered host writer.
// Scanout owns fixed read slots. Each stored pixel is shown as a 4x4 block.
// Host writes queue in a small FIFO and drain into the RAM in every cycle
// that has no scanout read.
//
// Ports:
//   clock25     pixel clock, rising edge
//   reset       asynchronous, active-low
//   pixel_x/y   sync generator counters (0..799 / 0..524)
//   display_on  high inside the 640x480 active area
//   wr_valid/wr_addr/wr_data/wr_ready  host write handshake (linear address)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  framebuffer RAM port
//   rgb         pixel to the DAC, 0 outside the active area
//   vblank      registered pixel_y >= 480
//   fifo_level  host FIFO occupancy
module vga_fb_arbiter #(
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LINE_LAST   = 799,
    parameter int unsigned SCREEN_LAST = 524
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        display_on,
    input  logic        wr_valid,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  rgb,
    output logic        vblank,
    output logic [2:0]  fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [9:0]  SlotLimit  = 10'(FB_W * 4 - 4);   // 636: last in-line slot is 633
    localparam logic [9:0]  PrefetchX  = 10'(LINE_LAST - 2);  // 797: fetch col 0 of next line
    localparam logic [9:0]  ActiveH    = 10'(FB_H * 4);       // 480
    localparam logic [9:0]  ScreenLast = 10'(SCREEN_LAST);
    localparam logic [14:0] FbSize     = 15'(FB_W * FB_H);    // 19200
    localparam logic [2:0]  Depth      = 3'(FIFO_DEPTH);

    // Scanout slot decode
    logic        slot;
    logic        next_line_slot;
    logic [7:0]  tgt_col;
    logic [9:0]  tgt_line;
    logic [14:0] row_ext;
    logic [14:0] rd_addr;
    logic        rd_en;

    always_comb begin
        next_line_slot = (pixel_x == PrefetchX);
        slot           = (pixel_x[1:0] == 2'b01) && ((pixel_x < SlotLimit) || next_line_slot);
        tgt_col        = next_line_slot ? 8'd0 : (pixel_x[9:2] + 8'd1);
        if (!next_line_slot) begin
            tgt_line = pixel_y;
        end else if (pixel_y == ScreenLast) begin
            tgt_line = 10'd0;
        end else begin
            tgt_line = pixel_y + 10'd1;
        end
        rd_en   = slot && (tgt_line < ActiveH);
        row_ext = {7'd0, tgt_line[9:2]};
        // row*160 as row*128 + row*32
        rd_addr = (row_ext << 7) + (row_ext << 5) + {7'd0, tgt_col};
    end

    // Host write FIFO
    logic [14:0]     addr_q [FIFO_DEPTH];
    logic [14:0]     addr_d [FIFO_DEPTH];
    logic [7:0]      data_q [FIFO_DEPTH];
    logic [7:0]      data_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            push;
    logic            pop;
    logic [14:0]     head_addr;
    logic [7:0]      head_data;
    logic            head_ok;

    always_comb begin
        wr_ready  = (count_q < Depth);
        push      = wr_valid && wr_ready;
        pop       = !rd_en && (count_q != 3'd0);
        head_addr = addr_q[rd_ptr_q];
        head_data = data_q[rd_ptr_q];
        head_ok   = (head_addr < FbSize);

        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = wr_addr;
            data_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // RAM port: scanout read wins; otherwise the popped head is written if in range.
    // Gated by reset so nothing reaches the RAM while held in reset.
    always_comb begin
        ram_en    = reset && (rd_en || (pop && head_ok));
        ram_we    = reset && !rd_en && pop && head_ok;
        ram_addr  = rd_en ? rd_addr : head_addr;
        ram_wdata = head_data;
    end

    // Pixel pipeline: read at x%4==1, data valid at x%4==2, shown from x%4==0.
    logic [7:0] prefetch_q, prefetch_d;
    logic [7:0] pixel_q, pixel_d;
    logic       vblank_q, vblank_d;

    always_comb begin
        prefetch_d = (pixel_x[1:0] == 2'b10) ? ram_rdata : prefetch_q;
        pixel_d    = (pixel_x[1:0] == 2'b11) ? prefetch_q : pixel_q;
        vblank_d   = (pixel_y >= ActiveH);
    end

    always_ff @(posedge clock25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prefetch_q <= '0;
            pixel_q    <= '0;
            vblank_q   <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            prefetch_q <= prefetch_d;
            pixel_q    <= pixel_d;
            vblank_q   <= vblank_d;
        end
    end

    always_comb begin
        rgb        = display_on ? pixel_q : 8'h00;
        vblank     = vblank_q;
        fifo_level = count_q;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clock25 = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        display_on;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  rgb;
    logic        vblank;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int px = 0;
    int py = 0;

    vga_fb_arbiter dut (
        .clock25    (clock25),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .display_on (display_on),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .rgb        (rgb),
        .vblank     (vblank),
        .fifo_level (fifo_level)
    );

    always #20 clock25 = ~clock25;

    // Framebuffer RAM model with a log of every write it receives
    logic [7:0]  mem [19200];
    logic        preload = 1'b0;
    logic [22:0] wlog [$];

    always @(posedge clock25) begin
        if (preload) begin
            for (int i = 0; i < 19200; i++) mem[i] <= 8'(i);
        end else if (ram_en && ram_we) begin
            if (ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end else if (ram_en) begin
            ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 8'h00;
        end
    end

    task automatic drive();
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        display_on = (px < 640) && (py < 480);
    endtask

    // Next timing position; inputs change on the falling edge
    task automatic adv();
        @(negedge clock25);
        if (px == 799) begin
            px = 0;
            py = (py == 524) ? 0 : py + 1;
        end else begin
            px = px + 1;
        end
        drive();
        #1;
    endtask

    // One more clock with the sync inputs held
    task automatic hold();
        @(negedge clock25);
        #1;
    endtask

    task automatic jump(input int x, input int y);
        @(negedge clock25);
        px = x;
        py = y;
        drive();
        #1;
    endtask

    task automatic run_to(input int x, input int y);
        for (int i = 0; i < 2000; i++) begin
            if (px == x && py == y) break;
            adv();
        end
        checks++;
        if (px != x || py != y) begin
            errors++;
            $display("FAIL run_to position got %0d,%0d expected %0d,%0d", px, py, x, y);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 15'd5;
        wr_data  = 8'h55;
        px = 1;
        py = 0;
        drive();
        preload = 1'b1;
        @(negedge clock25);
        preload = 1'b0;
        hold();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready got %b expected 1", wr_ready);
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++; $display("FAIL reset_level got %0d expected 0", fifo_level);
        end
        checks++;
        if (ram_en !== 1'b0) begin
            errors++; $display("FAIL reset_ram_en got %b expected 0", ram_en);
        end
        checks++;
        if (rgb !== 8'h00) begin
            errors++; $display("FAIL reset_rgb got %h expected 00", rgb);
        end
        wr_valid = 1'b0;
        jump(700, 0);
        reset    = 1'b1;
        wr_valid = 1'b1;
        adv();
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++; $display("FAIL first_push_level got %0d expected 1", fifo_level);
        end
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd5 || ram_wdata !== 8'h55) begin
            errors++;
            $display("FAIL first_drain got en=%b we=%b addr=%0d data=%h expected 1 1 5 55",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        adv();
        checks++;
        if (fifo_level !== 3'd0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL after_drain got level=%0d en=%b expected 0 0", fifo_level, ram_en);
        end
    endtask

    task automatic test_frame();
        jump(790, 3);
        run_to(797, 3);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd160) begin
            errors++;
            $display("FAIL prefetch_y3 got en=%b we=%b addr=%0d expected 1 0 160",
                     ram_en, ram_we, ram_addr);
        end
        run_to(0, 4);
        checks++;
        if (rgb !== 8'hA0) begin
            errors++; $display("FAIL rgb_x0_y4 got %h expected a0", rgb);
        end
        adv();
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 15'd161) begin
            errors++; $display("FAIL slot_x1_y4 got en=%b addr=%0d expected 1 161", ram_en, ram_addr);
        end
        run_to(4, 4);
        checks++;
        if (rgb !== 8'hA1) begin
            errors++; $display("FAIL rgb_x4_y4 got %h expected a1", rgb);
        end
        run_to(8, 4);
        checks++;
        if (rgb !== 8'hA2) begin
            errors++; $display("FAIL rgb_x8_y4 got %h expected a2", rgb);
        end
        run_to(633, 4);
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 15'd319) begin
            errors++; $display("FAIL slot_x633 got en=%b addr=%0d expected 1 319", ram_en, ram_addr);
        end
        run_to(637, 4);
        checks++;
        if (ram_en !== 1'b0) begin
            errors++; $display("FAIL noslot_x637 got en=%b expected 0", ram_en);
        end
        jump(795, 479);
        run_to(797, 479);
        checks++;
        if (ram_en !== 1'b0) begin
            errors++; $display("FAIL noread_line480 got en=%b expected 0", ram_en);
        end
        run_to(0, 480);
        checks++;
        if (vblank !== 1'b0 || rgb !== 8'h00) begin
            errors++; $display("FAIL vblank_delay got vb=%b rgb=%h expected 0 00", vblank, rgb);
        end
        adv();
        checks++;
        if (vblank !== 1'b1) begin
            errors++; $display("FAIL vblank_set got %b expected 1", vblank);
        end
        jump(795, 524);
        run_to(797, 524);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd0) begin
            errors++;
            $display("FAIL prefetch_wrap got en=%b we=%b addr=%0d expected 1 0 0",
                     ram_en, ram_we, ram_addr);
        end
        run_to(1, 0);
        checks++;
        if (vblank !== 1'b0) begin
            errors++; $display("FAIL vblank_clear got %b expected 0", vblank);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int exp_lvl [9] = '{0, 1, 1, 1, 1, 2, 2, 1, 0};
        n0 = wlog.size();
        jump(1, 10);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (((px % 4) == 1 && ram_we !== 1'b0) || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_slot x=%0d got we=%b ready=%b", px, ram_we, wr_ready);
            end
            checks++;
            if (fifo_level !== 3'(exp_lvl[c])) begin
                errors++;
                $display("FAIL b2b_level x=%0d got %0d expected %0d", px, fifo_level, exp_lvl[c]);
            end
            wr_valid = (c < 6);
            wr_addr  = 15'(1000 + c);
            wr_data  = 8'(16 + c);
            adv();
        end
        wr_valid = 1'b0;
        adv();
        checks++;
        if (wlog.size() != n0 + 6) begin
            errors++; $display("FAIL b2b_count got %0d expected 6", wlog.size() - n0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[n0 + i] !== {15'(1000 + i), 8'(16 + i)}) begin
                    errors++; $display("FAIL b2b_order idx=%0d got %h expected %h", i,
                                       wlog[n0 + i], {15'(1000 + i), 8'(16 + i)});
                end
            end
        end
    endtask

    task automatic test_full();
        int n0;
        n0 = wlog.size();
        jump(1, 10);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_ready !== 1'b1 || fifo_level !== 3'(i)) begin
                errors++;
                $display("FAIL fill_%0d got ready=%b level=%0d expected 1 %0d",
                         i, wr_ready, fifo_level, i);
            end
            wr_valid = 1'b1;
            wr_addr  = 15'(2000 + i);
            wr_data  = 8'(32 + i);
            hold();
        end
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full got level=%0d ready=%b expected 4 0", fifo_level, wr_ready);
        end
        wr_addr = 15'd2004;
        wr_data = 8'h24;
        hold();
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got level=%0d ready=%b we=%b expected 4 0 0",
                     fifo_level, wr_ready, ram_we);
        end
        adv();
        checks++;
        if (fifo_level !== 3'd4 || wr_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 15'd2000) begin
            errors++;
            $display("FAIL full_drain got level=%0d ready=%b we=%b addr=%0d expected 4 0 1 2000",
                     fifo_level, wr_ready, ram_we, ram_addr);
        end
        adv();
        checks++;
        if (fifo_level !== 3'd3 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_free got level=%0d ready=%b expected 3 1", fifo_level, wr_ready);
        end
        adv();
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL push_pop_same got %0d expected 3", fifo_level);
        end
        for (int i = 0; i < 8; i++) adv();
        checks++;
        if (wlog.size() != n0 + 5 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL full_count got %0d level=%0d expected 5 0", wlog.size() - n0, fifo_level);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wlog[n0 + i] !== {15'(2000 + i), 8'(32 + i)}) begin
                    errors++; $display("FAIL full_order idx=%0d got %h expected %h", i,
                                       wlog[n0 + i], {15'(2000 + i), 8'(32 + i)});
                end
            end
        end
    endtask

    task automatic test_discard();
        int n0;
        n0 = wlog.size();
        jump(700, 10);
        wr_valid = 1'b1;
        wr_addr  = 15'd19200;
        wr_data  = 8'hFF;
        adv();
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL discard_pop got level=%0d en=%b expected 1 0", fifo_level, ram_en);
        end
        wr_valid = 1'b1;
        wr_addr  = 15'd19199;
        wr_data  = 8'h77;
        adv();
        wr_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || ram_en !== 1'b1 || ram_we !== 1'b1 ||
            ram_addr !== 15'd19199 || ram_wdata !== 8'h77) begin
            errors++;
            $display("FAIL last_addr got level=%0d en=%b we=%b addr=%0d data=%h",
                     fifo_level, ram_en, ram_we, ram_addr, ram_wdata);
        end
        adv();
        checks++;
        if (fifo_level !== 3'd0 || wlog.size() != n0 + 1) begin
            errors++;
            $display("FAIL discard_log got level=%0d writes=%0d expected 0 1",
                     fifo_level, wlog.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        jump(290, 10);
        run_to(300, 10);
        checks++;
        if (rgb !== 8'h8B) begin
            errors++; $display("FAIL rgb_x300_y10 got %h expected 8b", rgb);
        end
        adv();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 15'(3000 + i);
            wr_data  = 8'(48 + i);
            hold();
        end
        wr_valid = 1'b0;
        n0 = wlog.size();
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL queued3 got %0d expected 3", fifo_level);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || rgb !== 8'h00 || ram_en !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got level=%0d rgb=%h en=%b ready=%b expected 0 00 0 1",
                     fifo_level, rgb, ram_en, wr_ready);
        end
        adv();
        adv();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) adv();
        checks++;
        if (wlog.size() != n0) begin
            errors++; $display("FAIL reset_discard got %0d writes expected 0", wlog.size() - n0);
        end
    endtask

    initial begin
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        test_reset();
        test_frame();
        test_back_to_back();
        test_full();
        test_discard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
